// File: rtl/qei_speed.sv
// Quadrature encoder front end: sync + glitch filter, x4 decode, position and windowed speed.
// Optional index line (zeroes pos_o on a filtered rising edge) is enabled by defining QEI_INDEX_EN.
`ifndef PID_RES
`define PID_RES 32
`endif

module qei_speed #(
  parameter int nbits      = `PID_RES,
  parameter int SAMPLE_DIV = 50000,
  parameter int FILT_LEN   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             a_i,
  input  logic             b_i,
`ifdef QEI_INDEX_EN
  input  logic             z_i,
`endif
  output logic [nbits-1:0] pos_o,
  output logic [nbits-1:0] pv_o,
  output logic             pid_en_o,
  output logic             err_o
);

`ifdef QEI_INDEX_EN
  localparam int NL = 3;
`else
  localparam int NL = 2;
`endif
  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int SW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] FMAX  = CW'(FILT_LEN - 1);
  localparam logic [SW-1:0] STERM = SW'(SAMPLE_DIV - 1);
  localparam logic [nbits-1:0] ONE = {{(nbits-1){1'b0}}, 1'b1};

  logic [NL-1:0] din;
  logic [NL-1:0] sync1;
  logic [NL-1:0] sync2;
  logic [NL-1:0] filt;
  logic [CW-1:0] cnt [NL];

  logic [1:0]       prev;
  logic             primed;
  logic [nbits-1:0] delta;
  logic             illegal;
  logic             index_zero;
  logic [SW-1:0]    scnt;
  logic [nbits-1:0] acc;

`ifdef QEI_INDEX_EN
  assign din = {z_i, a_i, b_i};
`else
  assign din = {a_i, b_i};
`endif

  // A line's filtered level moves only after FILT_LEN consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      filt  <= '0;
      for (int i = 0; i < NL; i++) cnt[i] <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      for (int i = 0; i < NL; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == FMAX) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  function automatic logic [1:0] phase(input logic [1:0] ab);
    case (ab)
      2'b00:   phase = 2'd0;
      2'b01:   phase = 2'd1;
      2'b11:   phase = 2'd2;
      default: phase = 2'd3;
    endcase
  endfunction

  // prev tracks the filtered pair even during clr so nothing is counted once clr drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev   <= 2'b00;
      primed <= 1'b0;
    end else begin
      prev   <= filt[1:0];
      primed <= 1'b1;
    end
  end

  always_comb begin
    logic [1:0] d;
    delta   = '0;
    illegal = 1'b0;
    d       = phase(filt[1:0]) - phase(prev);
    if (primed) begin
      case (d)
        2'd1:    delta = ONE;
        2'd3:    delta = '1;
        2'd2:    illegal = 1'b1;
        default: delta = '0;
      endcase
    end
  end

`ifdef QEI_INDEX_EN
  logic z_q;
  always_ff @(posedge clk) begin
    if (rst) z_q <= 1'b0;
    else     z_q <= filt[2];
  end
  assign index_zero = filt[2] & ~z_q;
`else
  assign index_zero = 1'b0;
`endif

  // A count on the terminal cycle is folded into the window being published.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pos_o    <= '0;
      pv_o     <= '0;
      pid_en_o <= 1'b0;
      err_o    <= 1'b0;
      scnt     <= '0;
      acc      <= '0;
    end else begin
      pos_o <= index_zero ? '0 : pos_o + delta;
      err_o <= err_o | illegal;
      if (scnt == STERM) begin
        scnt     <= '0;
        pv_o     <= acc + delta;
        acc      <= '0;
        pid_en_o <= 1'b1;
      end else begin
        scnt     <= scnt + 1'b1;
        acc      <= acc + delta;
        pid_en_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qei_speed.sv
// Bench for qei_speed: pin-level stimulus, event-queue reference model checked every cycle.
module tb_qei_speed;
  localparam int SD  = 100;
  localparam int F   = 3;
  localparam int LAT = 3 + F;

  logic        clk = 1'b0;
  logic        rst, clr, a_i, b_i;
`ifdef QEI_INDEX_EN
  logic        z_i;
`endif
  logic [31:0] pos_o, pv_o;
  logic        pid_en_o, err_o;

  qei_speed #(.nbits(32), .SAMPLE_DIV(SD), .FILT_LEN(F)) dut (
    .clk(clk), .rst(rst), .clr(clr), .a_i(a_i), .b_i(b_i),
`ifdef QEI_INDEX_EN
    .z_i(z_i),
`endif
    .pos_o(pos_o), .pv_o(pv_o), .pid_en_o(pid_en_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t;
    int d;
    bit idx;
    bit er;
  } ev_t;

  ev_t         ev_q[$];
  int          total = 0;
  int          bad   = 0;
  int          n     = 0;
  int          n0    = 0;
  int          ph    = 0;
  logic [31:0] m_pos = 0, m_acc = 0, m_pv = 0;
  logic        m_en  = 0, m_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s at cycle %0d: got %h expected %h", tag, n, got, exp);
    end
  endtask

  function automatic int ph_of(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] ab_of(input int p);
    case (p & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Drive a new clean A/B pair; its effect lands LAT edges later.
  task automatic set_ab(input logic [1:0] ab);
    int np, dd;
    ev_t e;
    np = ph_of(ab);
    dd = (np - ph) & 3;
    e.t = n + LAT; e.idx = 1'b0; e.er = 1'b0; e.d = 0;
    if (dd == 1) e.d = 1;
    else if (dd == 3) e.d = -1;
    else if (dd == 2) e.er = 1'b1;
    if (dd != 0) ev_q.push_back(e);
    ph = np;
    {a_i, b_i} = ab;
  endtask

  task automatic step(input int dir);
    set_ab(ab_of(ph + dir));
  endtask

  task automatic tick();
    int  d;
    bit  iz, ie;
    d = 0; iz = 0; ie = 0;
    @(posedge clk);
    n++;
    for (int i = ev_q.size() - 1; i >= 0; i--) begin
      if (ev_q[i].t == n) begin
        d  += ev_q[i].d;
        iz |= ev_q[i].idx;
        ie |= ev_q[i].er;
        ev_q.delete(i);
      end
    end
    if (rst || clr) begin
      m_pos = 0; m_acc = 0; m_pv = 0; m_en = 0; m_err = 0;
      n0 = n;
    end else begin
      m_pos = iz ? 32'd0 : m_pos + 32'(d);
      if (ie) m_err = 1'b1;
      if ((n - n0) % SD == 0) begin
        m_pv  = m_acc + 32'(d);
        m_acc = 0;
        m_en  = 1'b1;
      end else begin
        m_acc = m_acc + 32'(d);
        m_en  = 1'b0;
      end
    end
    #1;
    chk("pos", pos_o, m_pos);
    chk("pv", pv_o, m_pv);
    chk("pid_en", {31'd0, pid_en_o}, {31'd0, m_en});
    chk("err", {31'd0, err_o}, {31'd0, m_err});
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; a_i = 1'b0; b_i = 1'b0;
`ifdef QEI_INDEX_EN
    z_i = 1'b0;
`endif
    ticks(5);
    rst = 1'b0;
    ticks(99);
    chk("first_strobe_pre", {31'd0, pid_en_o}, 32'd0);
    tick();
    chk("first_strobe", {31'd0, pid_en_o}, 32'd1);
    chk("first_pv", pv_o, 32'd0);

    for (int i = 0; i < 10; i++) begin
      step(1);
      ticks(5);
    end
    ticks(10);
    chk("fwd_pos", pos_o, 32'd10);
    ticks(200);

    pulse_clr();
    for (int i = 0; i < 3; i++) begin
      step(-1);
      ticks(5);
    end
    ticks(10);
    chk("rev_pos", pos_o, 32'hFFFF_FFFD);
    ticks(110);

    a_i = ~a_i;
    ticks(2);
    a_i = ~a_i;
    ticks(12);
    chk("glitch2_pos", pos_o, 32'hFFFF_FFFD);
    set_ab({~a_i, b_i});
    ticks(3);
    set_ab({~a_i, b_i});
    ticks(15);

    set_ab(~{a_i, b_i});
    ticks(15);
    chk("err_set", {31'd0, err_o}, 32'd1);
    chk("err_pos", pos_o, 32'hFFFF_FFFD);
    pulse_clr();
    ticks(12);
    chk("clr_err", {31'd0, err_o}, 32'd0);
    chk("clr_pos", pos_o, 32'd0);

    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 1) == 1) ? 1 : -1);
      ticks($urandom_range(4, 12));
    end
    ticks(250);

`ifdef QEI_INDEX_EN
    pulse_clr();
    for (int i = 0; i < 57; i++) begin
      step(1);
      ticks(4);
    end
    ticks(10);
    chk("idx_pre", pos_o, 32'd57);
    begin
      ev_t e;
      e.t = n + LAT; e.d = 0; e.idx = 1'b1; e.er = 1'b0;
      ev_q.push_back(e);
      z_i = 1'b1;
      ticks(5);
      z_i = 1'b0;
      ticks(15);
      chk("idx_zero", pos_o, 32'd0);
      e.t = n + LAT;
      ev_q.push_back(e);
      z_i = 1'b1;
      step(1);
      ticks(5);
      z_i = 1'b0;
      ticks(15);
      chk("idx_step_pos", pos_o, 32'd0);
      ticks(SD + 10);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
